// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants for the two-port memory arbiter.
// Holds the 2-bit FSM state encoding, the state enum built on it, and the
// default address/data width and read latency used by the arbiter and its
// bus interface.
package mem_arbiter_pkg;

    // Default geometry: 16 words of 8 bits, two-cycle registered memory read.
    localparam int unsigned AW_DEF     = 4;
    localparam int unsigned DW_DEF     = 8;
    localparam int unsigned RD_LAT_DEF = 2;

    // Latency counter only ever holds RD_LAT-1 with RD_LAT in 1..3.
    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RD_WAIT = 2'd2;
    localparam logic [1:0] ST_RD_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        RD_WAIT = ST_RD_WAIT,
        RD_DONE = ST_RD_DONE
    } arb_state_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the requester-side handshakes and the memory-side
// bus of the arbiter.
//   requesters : req0/1, we0/1, addr0/1, wdata0/1 -> arbiter
//                gnt0/1, rvalid0/1, rdata0/1      <- arbiter
//   memory     : mem_write, mem_read, mem_addr, mem_wdata <- arbiter
//                mem_rdata                                -> arbiter
//   status     : busy <- arbiter
// Modports: slave = the arbiter's view, master = the environment's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_write, mem_read, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_write, mem_read, mem_addr, mem_wdata, busy
    );

endinterface : mem_arbiter_if

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational two-way request selector.
//   req0_i, req1_i : pending requests
//   last_i         : port granted most recently (0/1)
//   fixed_i        : 1 = port 0 always wins a tie, 0 = round-robin on last_i
//   winner_o       : selected port (only meaningful when a request is pending)
module mem_arb_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    input  logic fixed_i,
    output logic winner_o
);

    // Tie goes to the port that was not served last, unless fixed priority.
    always_comb begin
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            winner_o = fixed_i ? 1'b0 : ~last_i;
        end else begin
            winner_o = req1_i;
        end
    end

endmodule : mem_arb_pick

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two requesters onto one single-port memory with a
// registered read output. One transaction is in flight at a time.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   bus       : mem_arbiter_if.slave (requester handshakes + memory bus)
// The memory-side strobes/address/data are registered from the FSM state, so
// they trail the state by one cycle: gnt and ISSUE share a cycle, mem_write or
// the first mem_read cycle follows it, and a read's data is sampled in the
// RD_DONE cycle, RD_LAT cycles after mem_read first rose.
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// every tie, no last-grant pointer); otherwise ties are round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW     = AW_DEF,
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned RD_LAT = RD_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_e       state_q,     state_d;
    logic             we_q,        we_d;
    logic [AW-1:0]    addr_q,      addr_d;
    logic [DW-1:0]    wdata_q,     wdata_d;
    logic             port_q,      port_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             gnt0_q,      gnt0_d;
    logic             gnt1_q,      gnt1_d;
    logic             rvalid0_q,   rvalid0_d;
    logic             rvalid1_q,   rvalid1_d;
    logic [DW-1:0]    rdata0_q,    rdata0_d;
    logic [DW-1:0]    rdata1_q,    rdata1_d;
    logic             mem_write_q, mem_write_d;
    logic             mem_read_q,  mem_read_d;
    logic [AW-1:0]    mem_addr_q,  mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic             busy_q,      busy_d;
    logic             winner;

`ifdef MEM_ARB_FIXED_PRIO_EN
    mem_arb_pick u_pick (
        .req0_i   (bus.req0),
        .req1_i   (bus.req1),
        .last_i   (1'b0),
        .fixed_i  (1'b1),
        .winner_o (winner)
    );
`else
    logic last_q, last_d;

    mem_arb_pick u_pick (
        .req0_i   (bus.req0),
        .req1_i   (bus.req1),
        .last_i   (last_q),
        .fixed_i  (1'b0),
        .winner_o (winner)
    );
`endif

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        port_d      = port_q;
        cnt_d       = cnt_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d      = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                    we_d    = winner ? bus.we1    : bus.we0;
                    addr_d  = winner ? bus.addr1  : bus.addr0;
                    wdata_d = winner ? bus.wdata1 : bus.wdata0;
                    port_d  = winner;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr_d  = addr_q;
                mem_wdata_d = wdata_q;
                if (we_q) begin
                    mem_write_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    mem_read_d = 1'b1;
                    cnt_d      = CNT_W'(RD_LAT - 1);
                    state_d    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                mem_read_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_DONE: begin
                if (port_q) begin
                    rdata1_d  = bus.mem_rdata;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = bus.mem_rdata;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            port_q      <= 1'b0;
            cnt_q       <= '0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            port_q      <= port_d;
            cnt_q       <= cnt_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small memory model
// (write on mem_write, RD_LAT-stage read pipeline fed while mem_read is high).
module tb_mem_arbiter;

    localparam int unsigned AW     = 4;
    localparam int unsigned DW     = 8;
    localparam int unsigned RD_LAT = 2;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model.
    logic [DW-1:0] mem  [16];
    logic [DW-1:0] pipe [RD_LAT];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < int'(RD_LAT); i++) pipe[i] = '0;
    end

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        pipe[0] <= bus.mem_read ? mem[bus.mem_addr] : '0;
        for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end

    assign bus.mem_rdata = pipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [1:0] exp_gnt [4];
    logic       seen;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
`endif

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",    {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
        chk("rst_memctl", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
        chk("rst_busy",   32'(bus.busy), 32'd0);
        chk("rst_addr",   32'(bus.mem_addr), 32'd0);
        chk("rst_wdata",  32'(bus.mem_wdata), 32'd0);
        chk("rst_rdata",  {16'd0, bus.rdata1, bus.rdata0}, 32'd0);
        rst = 1'b1;
        tick();

        // Single write from port 0.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h3; bus.wdata0 = 8'hA5;
        tick();
        chk("wr_gnt",     {30'd0, bus.gnt1, bus.gnt0}, 32'b01);
        chk("wr_busy",    32'(bus.busy), 32'd1);
        chk("wr_nowrite", 32'(bus.mem_write), 32'd0);
        bus.req0 = 1'b0;
        tick();
        chk("wr_write",   {30'd0, bus.mem_write, bus.mem_read}, 32'b10);
        chk("wr_addr",    32'(bus.mem_addr), 32'h3);
        chk("wr_data",    32'(bus.mem_wdata), 32'hA5);
        chk("wr_gnt_off", 32'(bus.gnt0), 32'd0);
        tick();
        chk("wr_pulse",   32'(bus.mem_write), 32'd0);

        // Read-back on port 1.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h3;
        tick();
        chk("rd_gnt", {30'd0, bus.gnt1, bus.gnt0}, 32'b10);
        bus.req1 = 1'b0;
        tick();
        chk("rd_memread", {30'd0, bus.mem_write, bus.mem_read}, 32'b01);
        chk("rd_addr", 32'(bus.mem_addr), 32'h3);
        chk("rd_rv_c1", 32'(bus.rvalid1), 32'd0);
        tick();
        chk("rd_rv_c2", 32'(bus.rvalid1), 32'd0);
        tick();
        chk("rd_rv_c3", 32'(bus.rvalid1), 32'd0);
        tick();
        chk("rd_rvalid", {30'd0, bus.rvalid1, bus.rvalid0}, 32'b10);
        chk("rd_data", 32'(bus.rdata1), 32'hA5);
        tick();
        chk("rd_rv_pulse", 32'(bus.rvalid1), 32'd0);
        chk("rd_data_hold", 32'(bus.rdata1), 32'hA5);

        // Contention: both ports hold write requests.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h5; bus.wdata0 = 8'h11;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'h6; bus.wdata1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 8; t++) begin
                if (bus.gnt0 || bus.gnt1) break;
                tick();
            end
            chk($sformatf("rr_gnt%0d", k), {30'd0, bus.gnt1, bus.gnt0}, 32'(exp_gnt[k]));
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            tick();
        end
        tick();

        // Port-0 read; port 1 raised while busy must wait for IDLE.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'h3;
        tick();
        chk("bb_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'b01);
        bus.req0 = 1'b0;
        tick();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'h7; bus.wdata1 = 8'h3C;
        chk("bb_c1", 32'(bus.gnt1), 32'd0);
        tick();
        chk("bb_c2", 32'(bus.gnt1), 32'd0);
        tick();
        chk("bb_c3", 32'(bus.gnt1), 32'd0);
        tick();
        chk("bb_c4", 32'(bus.gnt1), 32'd0);
        chk("bb_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("bb_rdata0", 32'(bus.rdata0), 32'hA5);
        tick();
        chk("bb_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'b10);
        bus.req1 = 1'b0;
        tick();
        chk("bb_write", 32'(bus.mem_write), 32'd1);
        chk("bb_waddr", 32'(bus.mem_addr), 32'h7);
        chk("bb_wdata", 32'(bus.mem_wdata), 32'h3C);
        tick();

        // Reset in RD_WAIT aborts the read.
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h7;
        tick();
        chk("ra_gnt1", 32'(bus.gnt1), 32'd1);
        bus.req1 = 1'b0;
        tick();
        chk("ra_reading", 32'(bus.mem_read), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ra_memread", 32'(bus.mem_read), 32'd0);
        chk("ra_busy", 32'(bus.busy), 32'd0);
        chk("ra_addr", 32'(bus.mem_addr), 32'd0);
        chk("ra_rdata1", 32'(bus.rdata1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (bus.rvalid1 || bus.rvalid0 || bus.busy) seen = 1'b1;
        end
        chk("ra_no_rvalid", 32'(seen), 32'd0);

        // After reset port 0 wins a tie.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'h7;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'h9; bus.wdata1 = 8'h5A;
        tick();
        chk("pr_gnt0", {30'd0, bus.gnt1, bus.gnt0}, 32'b01);
        bus.req0 = 1'b0;
        repeat (4) tick();
        chk("pr_rvalid0", 32'(bus.rvalid0), 32'd1);
        chk("pr_rdata0", 32'(bus.rdata0), 32'h3C);
        tick();
        chk("pr_gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'b10);

        // Request raised while busy and dropped before IDLE is never granted.
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'hF; bus.wdata0 = 8'hFF;
        tick();
        chk("wd_write", 32'(bus.mem_write), 32'd1);
        chk("wd_waddr", 32'(bus.mem_addr), 32'h9);
        chk("wd_wdata", 32'(bus.mem_wdata), 32'h5A);
        chk("wd_gnt_c6", 32'(bus.gnt0), 32'd0);
        bus.req0 = 1'b0;
        tick();
        chk("wd_gnt_c7", 32'(bus.gnt0), 32'd0);
        chk("wd_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("wd_gnt_c8", 32'(bus.gnt0), 32'd0);
        chk("wd_idle_mem", {30'd0, bus.mem_write, bus.mem_read}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 4, memory address width (16 words).
REQ-002 Parameter DW, default 8, memory data width.
REQ-003 Parameter RD_LAT, default 2, cycles from issuing a memory read to valid mem_rdata (range 1..3).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req0/req1  input  1  requester n asks for one access; held high until gntn.
REQ-007 we0/we1  input  1  1 = write, 0 = read; valid while reqn high.
REQ-008 addr0/addr1  input  AW  word address; valid while reqn high.
REQ-009 wdata0/wdata1  input  DW  write data; valid while reqn high.
REQ-010 gnt0/gnt1  output  1  single-cycle pulse; request accepted and its inputs captured.
REQ-011 rvalid0/rvalid1  output  1  single-cycle pulse; rdatan holds read result.
REQ-012 rdata0/rdata1  output  DW  read data, held until the next rvalid to the same port.
REQ-013 mem_write  output  1  memory write enable (wre).
REQ-014 mem_read  output  1  memory output-register enable (oce).
REQ-015 mem_addr  output  AW  memory address.
REQ-016 mem_wdata  output  DW  memory write data.
REQ-017 mem_rdata  input  DW  memory read data.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, RD_WAIT, RD_DONE; exactly one transaction in flight.
REQ-020 IDLE: if any reqn high, arbitrate, pulse winner's gnt, register its we/addr/wdata/port id, go to ISSUE; otherwise stay.
REQ-021 ISSUE: drive mem_addr/mem_wdata from captured values; write asserts mem_write for exactly this cycle then returns to IDLE; read asserts mem_read, loads latency counter with RD_LAT-1, goes to RD_WAIT.
REQ-022 RD_WAIT: mem_read stays high; counter decrements each cycle; at zero go to RD_DONE.
REQ-023 RD_DONE: capture mem_rdata into rdata of captured port, pulse its rvalid, return to IDLE.
REQ-024 Latency: write gnt to mem_write = 1 cycle; read gnt to rvalid = RD_LAT+2 cycles.
REQ-025 Simultaneous req0 and req1 in IDLE: round-robin; winner is the port not granted last; after reset port 0 has priority.
REQ-026 Requests arriving while busy are ignored until IDLE; no gnt is issued outside IDLE.
REQ-027 mem_write and mem_read are never high in the same cycle; outside ISSUE/RD_WAIT both are 0.
REQ-028 A requester dropping reqn before gntn withdraws the request without side effects.

Reset
REQ-029 rst low: state IDLE, gnt0/1, rvalid0/1, mem_write, mem_read, busy = 0; mem_addr, mem_wdata, rdata0/1 = 0; last-grant pointer = port 1.
REQ-030 Reset mid-transaction aborts it; no rvalid is issued for the aborted read; first cycle after release behaves as IDLE.

Configuration
REQ-031 MEM_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests and the last-grant pointer is removed; undefined: round-robin per REQ-025.

Structure
REQ-032 Shared package holds the FSM state encoding (2-bit localparams) and default AW/DW/RD_LAT constants.
REQ-033 One sub-module, mem_arb_pick, is the combinational two-way selector (req0, req1, last, fixed-mode) -> winner.

Verification
REQ-034 Single write: req0=1,we0=1,addr0=4'h3,wdata0=8'hA5 -> gnt0 next edge, mem_write=1 with mem_addr=3,mem_wdata=A5 for one cycle.
REQ-035 Read-back: req1 read addr 3 after above, RD_LAT=2 -> rvalid1 pulses 4 cycles after gnt1 with rdata1=8'hA5.
REQ-036 Contention: req0 and req1 held high for 4 transactions -> grants alternate 0,1,0,1 (with MEM_ARB_FIXED_PRIO_EN: 0,0,0,0 while req0 held).
REQ-037 Busy blocking: req1 raised during RD_WAIT of a port-0 read -> no gnt1 until state IDLE, then gnt1.
REQ-038 Reset abort: rst low during RD_WAIT -> all outputs 0 asynchronously, no rvalid after release, next request granted normally.
